slow_clk_timer: RTL and testbench
=================================

SLOW_CLK_TIMER -- requirements
Module: slow_clk_timer

Interface
REQ-001 The block SHALL have parameter INIT_SEC, default 8'h60: countdown start value, two-digit BCD (tens in [7:4], ones in [3:0]).
REQ-002 Port clk, input, 1 bit: system clock; all state SHALL update on its rising edge only.
REQ-003 Port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 Port clk_slow, input, 1 bit: divided square wave from the divider block, asynchronous to clk.
REQ-005 Port start, input, 1 bit: level sampled each cycle; high = load INIT_SEC and run.
REQ-006 Port pause, input, 1 bit: level sampled each cycle; high = toggle between running and paused.
REQ-007 Port tick, output, 1 bit: one-cycle pulse per rising edge of clk_slow.
REQ-008 Port sec_bcd, output, 8 bits: remaining seconds, BCD.
REQ-009 Port running, output, 1 bit: high while in RUN.
REQ-010 Port expired, output, 1 bit: high while in DONE.
REQ-011 Port timeout, output, 1 bit: one-cycle pulse on entry to DONE.

Function
REQ-012 clk_slow SHALL pass through a 2-flop synchronizer (s1, s2) and then into a history flop s3.
REQ-013 The registered output tick SHALL be high for exactly one cycle after any clk edge where s2=1, s3=0 and the primed flag is set.
- Latency: clk_slow rises before clk edge N; tick is high in the cycle following edge N+2.
REQ-014 The primed flag SHALL clear on reset and set on the first edge where s2=0.
- A clk_slow held high across reset release SHALL NOT produce a tick.
REQ-015 Falling edges of clk_slow SHALL NOT produce a tick.
REQ-016 The FSM SHALL have states IDLE, RUN, PAUSE, DONE; all outputs are registered.
REQ-017 In any state, start=1 SHALL load sec_bcd=INIT_SEC and enter RUN on the next edge; if INIT_SEC=8'h00, the block SHALL enter DONE instead and pulse timeout.
REQ-018 start SHALL have priority over pause and over a coincident tick; that tick SHALL be ignored.
REQ-019 In RUN with start=0, pause=1 SHALL move to PAUSE, and any coincident tick SHALL be ignored.
REQ-020 In PAUSE with start=0, pause=1 SHALL return to RUN; ticks in PAUSE SHALL NOT alter sec_bcd.
- pause is a level: held high, it toggles every cycle. The controller drives it as a one-cycle pulse.
REQ-021 In RUN, when tick=1 and start=pause=0, sec_bcd SHALL decrement in BCD.
- ones>0: ones-1.
- ones=0: ones=9 and tens-1 (e.g. 8'h60 -> 8'h59, 8'h10 -> 8'h09).
REQ-022 In RUN, when a tick decrements sec_bcd from 8'h01 to 8'h00, the same edge SHALL enter DONE, set expired=1, running=0, and pulse timeout for one cycle.
REQ-023 In DONE, sec_bcd SHALL hold 8'h00, ticks and pause SHALL be ignored, and only start leaves DONE.
REQ-024 pause and ticks SHALL be ignored in IDLE.
REQ-025 sec_bcd SHALL never hold a non-BCD digit or wrap below 8'h00.

Reset
REQ-026 On rst=1 at a clk edge, the following SHALL clear:
- state=IDLE
- sec_bcd=INIT_SEC
- tick=0, running=0, expired=0, timeout=0
- s1=s2=s3=0, primed=0
REQ-027 rst asserted mid-RUN or mid-PAUSE SHALL abort the count with no timeout pulse; rst SHALL have priority over all inputs.

Verification
REQ-028 With clk_slow toggling every 8 clk cycles and rst released while clk_slow=0, the bench SHALL see one tick per clk_slow rising edge, each 1 cycle wide, 3 edges after the rise, and none on falls.
REQ-029 With clk_slow=1 through reset release, the bench SHALL see no tick until clk_slow goes low and then high again.
REQ-030 With INIT_SEC=8'h12, start pulse, then 12 ticks, sec_bcd SHALL read 12,11,10,09,...,01,00; timeout SHALL pulse on the 00 edge, expired=1 and running=0.
REQ-031 With a pause pulse in RUN at sec_bcd=8'h07 followed by 5 ticks, sec_bcd SHALL stay 8'h07 and running=0; after a second pause pulse, the next tick SHALL give 8'h06.
REQ-032 With start in DONE, the block SHALL reload INIT_SEC and enter RUN; start coincident with tick and pause SHALL reload with no decrement and no pause.
REQ-033 With rst pulsed at sec_bcd=8'h03 in RUN, the bench SHALL see IDLE, sec_bcd=INIT_SEC, and no timeout pulse.

Source files
------------

// File: rtl/slow_clk_timer.sv
// slow_clk_timer: countdown timer in BCD seconds, advanced by rising edges
// of an asynchronous slow clock. Edge detection runs through a two-flop
// synchronizer plus a history flop; the FSM below consumes the resulting
// one-cycle tick.
//
// state | meaning
// IDLE  | after reset, waiting for start; ticks and pause ignored
// RUN   | counting down one second per tick
// PAUSE | count frozen, pause pulse resumes
// DONE  | reached 00, expired held until start
module slow_clk_timer #(
  parameter logic [7:0] INIT_SEC = 8'h60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_slow,
  input  logic       start,
  input  logic       pause,
  output logic       tick,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       expired,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] sec_q, sec_d;
  logic       running_q, expired_q, timeout_q, timeout_d;
  logic       s1_q, s2_q, s3_q;
  logic       v1_q, v2_q;
  logic       primed_q;
  logic       tick_q;

  // BCD decrement; callers never pass 8'h00, so no wrap below zero.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd0) r = {v[7:4] - 4'd1, 4'd9};
    else                r = {v[7:4], v[3:0] - 4'd1};
    return r;
  endfunction

  // Synchronize clk_slow, detect rising edges, and arm detection only after
  // a genuine low sample. v1/v2 mark when s2 holds a real sample rather than
  // its reset value, so a clk_slow held high across reset cannot tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      primed_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      s1_q   <= clk_slow;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      v1_q   <= 1'b1;
      v2_q   <= v1_q;
      if (v2_q && !s2_q) primed_q <= 1'b1;
      tick_q <= s2_q & ~s3_q & primed_q;
    end
  end

  // State, count and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sec_q     <= INIT_SEC;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sec_q     <= sec_d;
      running_q <= (state_d == RUN);
      expired_q <= (state_d == DONE);
      timeout_q <= timeout_d;
    end
  end

  // Next state: start beats pause beats tick.
  always_comb begin
    state_d   = state_q;
    sec_d     = sec_q;
    timeout_d = 1'b0;
    if (start) begin
      sec_d = INIT_SEC;
      if (INIT_SEC == 8'h00) begin
        state_d   = DONE;
        timeout_d = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (pause) begin
            state_d = PAUSE;
          end else if (tick_q) begin
            if (sec_q <= 8'h01) begin
              sec_d     = 8'h00;
              state_d   = DONE;
              timeout_d = 1'b1;
            end else begin
              sec_d = bcd_dec(sec_q);
            end
          end
        end
        PAUSE: begin
          if (pause) state_d = RUN;
        end
        DONE: begin
          sec_d = 8'h00;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  assign tick    = tick_q;
  assign sec_bcd = sec_q;
  assign running = running_q;
  assign expired = expired_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_slow_clk_timer.sv
// Directed bench for slow_clk_timer with INIT_SEC=8'h12, plus a second
// instance with INIT_SEC=8'h00 sharing the same inputs.
module tb_slow_clk_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_slow;
  logic       start;
  logic       pause;
  logic       tick;
  logic [7:0] sec_bcd;
  logic       running;
  logic       expired;
  logic       timeout;
  logic       z_tick;
  logic [7:0] z_sec;
  logic       z_running;
  logic       z_expired;
  logic       z_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  slow_clk_timer #(.INIT_SEC(8'h12)) dut (
    .clk(clk), .rst(rst), .clk_slow(clk_slow), .start(start), .pause(pause),
    .tick(tick), .sec_bcd(sec_bcd), .running(running), .expired(expired),
    .timeout(timeout)
  );

  slow_clk_timer #(.INIT_SEC(8'h00)) dut_zero (
    .clk(clk), .rst(rst), .clk_slow(clk_slow), .start(start), .pause(pause),
    .tick(z_tick), .sec_bcd(z_sec), .running(z_running), .expired(z_expired),
    .timeout(z_timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full clk_slow period: rise, tick after 3 edges, FSM consumes it on
  // the 4th edge, then fall and let the synchronizer settle low.
  task automatic slow_tick(input logic [7:0] exp_sec, input logic exp_run,
                           input logic exp_exp, input logic exp_to);
    clk_slow = 1'b1;
    step(); step(); step();
    chk("tick_hi", {7'd0, tick}, 8'd1);
    step();
    chk("sec", sec_bcd, exp_sec);
    chk("running", {7'd0, running}, {7'd0, exp_run});
    chk("expired", {7'd0, expired}, {7'd0, exp_exp});
    chk("timeout", {7'd0, timeout}, {7'd0, exp_to});
    chk("tick_one_cycle", {7'd0, tick}, 8'd0);
    clk_slow = 1'b0;
    step();
    chk("timeout_clear", {7'd0, timeout}, 8'd0);
    step(); step();
  endtask

  initial begin
    logic [7:0] cnt_exp [0:11];
    cnt_exp = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06,
                8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};

    rst = 1'b1; clk_slow = 1'b0; start = 1'b0; pause = 1'b0;
    step(); step(); step();
    chk("rst_tick", {7'd0, tick}, 8'd0);
    chk("rst_sec", sec_bcd, 8'h12);
    chk("rst_running", {7'd0, running}, 8'd0);
    chk("rst_expired", {7'd0, expired}, 8'd0);
    chk("rst_timeout", {7'd0, timeout}, 8'd0);
    rst = 1'b0;
    step(); step(); step(); step();

    // Free-running clk_slow, 8 clk per half period, FSM idle.
    for (int p = 0; p < 3; p++) begin
      clk_slow = 1'b1;
      for (int i = 1; i <= 8; i++) begin
        step();
        chk("rise_tick", {7'd0, tick}, (i == 3) ? 8'd1 : 8'd0);
      end
      clk_slow = 1'b0;
      for (int i = 1; i <= 8; i++) begin
        step();
        chk("fall_tick", {7'd0, tick}, 8'd0);
      end
    end
    chk("idle_sec", sec_bcd, 8'h12);
    chk("idle_running", {7'd0, running}, 8'd0);

    // pause ignored in IDLE
    pause = 1'b1; step(); pause = 1'b0;
    chk("idle_pause_running", {7'd0, running}, 8'd0);
    step();
    chk("idle_pause_state", {7'd0, running}, 8'd0);

    // start, with the zero-init instance going straight to DONE
    start = 1'b1; step(); start = 1'b0;
    chk("start_running", {7'd0, running}, 8'd1);
    chk("start_sec", sec_bcd, 8'h12);
    chk("start_timeout", {7'd0, timeout}, 8'd0);
    chk("zero_expired", {7'd0, z_expired}, 8'd1);
    chk("zero_timeout", {7'd0, z_timeout}, 8'd1);
    chk("zero_sec", z_sec, 8'h00);
    step();
    chk("zero_timeout_clear", {7'd0, z_timeout}, 8'd0);

    // full countdown 12 -> 00
    for (int k = 0; k < 12; k++)
      slow_tick(cnt_exp[k], (k == 11) ? 1'b0 : 1'b1, (k == 11) ? 1'b1 : 1'b0,
                (k == 11) ? 1'b1 : 1'b0);

    // DONE ignores tick and pause
    slow_tick(8'h00, 1'b0, 1'b1, 1'b0);
    pause = 1'b1; step(); pause = 1'b0;
    chk("done_pause_expired", {7'd0, expired}, 8'd1);
    chk("done_pause_running", {7'd0, running}, 8'd0);

    // restart from DONE
    start = 1'b1; step(); start = 1'b0;
    chk("restart_sec", sec_bcd, 8'h12);
    chk("restart_running", {7'd0, running}, 8'd1);
    chk("restart_expired", {7'd0, expired}, 8'd0);

    // start coincident with tick and pause: reload, no decrement, no pause
    slow_tick(8'h11, 1'b1, 1'b0, 1'b0);
    clk_slow = 1'b1;
    step(); step(); step();
    chk("coinc_tick", {7'd0, tick}, 8'd1);
    start = 1'b1; pause = 1'b1;
    step();
    start = 1'b0; pause = 1'b0;
    chk("coinc_sec", sec_bcd, 8'h12);
    chk("coinc_running", {7'd0, running}, 8'd1);
    clk_slow = 1'b0;
    step(); step(); step();

    // count to 07, pause, ticks frozen, resume
    slow_tick(8'h11, 1'b1, 1'b0, 1'b0);
    slow_tick(8'h10, 1'b1, 1'b0, 1'b0);
    slow_tick(8'h09, 1'b1, 1'b0, 1'b0);
    slow_tick(8'h08, 1'b1, 1'b0, 1'b0);
    slow_tick(8'h07, 1'b1, 1'b0, 1'b0);
    pause = 1'b1; step(); pause = 1'b0;
    chk("paused_running", {7'd0, running}, 8'd0);
    for (int k = 0; k < 5; k++) slow_tick(8'h07, 1'b0, 1'b0, 1'b0);
    pause = 1'b1; step(); pause = 1'b0;
    chk("resume_running", {7'd0, running}, 8'd1);
    slow_tick(8'h06, 1'b1, 1'b0, 1'b0);
    slow_tick(8'h05, 1'b1, 1'b0, 1'b0);
    slow_tick(8'h04, 1'b1, 1'b0, 1'b0);
    slow_tick(8'h03, 1'b1, 1'b0, 1'b0);

    // reset mid-RUN at 03
    rst = 1'b1; step();
    chk("midrst_sec", sec_bcd, 8'h12);
    chk("midrst_running", {7'd0, running}, 8'd0);
    chk("midrst_expired", {7'd0, expired}, 8'd0);
    chk("midrst_timeout", {7'd0, timeout}, 8'd0);
    rst = 1'b0; step();
    chk("postrst_timeout", {7'd0, timeout}, 8'd0);
    chk("postrst_running", {7'd0, running}, 8'd0);

    // clk_slow held high through reset release: no tick until low then high
    clk_slow = 1'b1;
    rst = 1'b1; step(); step(); step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("held_high_no_tick", {7'd0, tick}, 8'd0);
    end
    clk_slow = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("held_fall_no_tick", {7'd0, tick}, 8'd0);
    end
    clk_slow = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("rearm_tick", {7'd0, tick}, (i == 3) ? 8'd1 : 8'd0);
    end
    chk("rearm_idle_sec", sec_bcd, 8'h12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
